ws2801_multi_driver: RTL and testbench

WS2801_MULTI_DRIVER -- requirements
Module: ws2801_multi_driver

---
 rtl/ws2801_multi_driver.sv | 178 +++++++++++++++++
 tb/tb_ws2801_multi_driver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2801_multi_driver.sv
// ws2801_multi_driver: drives CHANNELS WS2801 strips in lockstep off one shared sclk.
// Latency: first bit on sdo in the cycle after the accept edge; done 24*LEDS*SCLK_DIV + LATCH_CYCLES cycles after accept.
// Backpressure: start is level-sensitive and ignored while busy; held high, frames issue with one idle cycle between them.
module ws2801_multi_driver #(
    parameter int LEDS     = 50,
    parameter int CHANNELS = 4,
    parameter int FREQ     = 12_500_000,
    parameter int SCLK_DIV = 4,
    parameter int LATCH_US = 500
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*LEDS*24-1:0]  led_rgb,
    input  logic [7:0]                   brightness,
    input  logic [1:0]                   order,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         sclk,
    output logic [CHANNELS-1:0]          sdo
);

    localparam int SLICE        = LEDS * 24;
    localparam int NBITS        = SLICE;
    localparam int LATCH_CYCLES = (FREQ / 1_000_000) * LATCH_US;
    // A zero-length gap still needs one LATCH cycle to return through the state machine.
    localparam int LAT_N        = (LATCH_CYCLES < 1) ? 1 : LATCH_CYCLES;

    localparam int BIT_W = $clog2(NBITS);
    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int LAT_W = (LAT_N > 1) ? $clog2(LAT_N) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LAT_N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t             state;
    logic [BIT_W-1:0]   bit_cnt;
    logic [4:0]         bit_in_word;
    logic [DIV_W-1:0]   div_cnt;
    logic [LAT_W-1:0]   lat_cnt;

    // Remaining (not yet loaded) words of each strip, next word at the top.
    logic [SLICE-1:0]   shadow [CHANNELS];
    logic [7:0]         shadow_bright;
    logic [1:0]         shadow_order;
    // Bits of the current word still to be sent after the one on sdo.
    logic [22:0]        word_sr [CHANNELS];

    logic [23:0]        first_word [CHANNELS];
    logic [23:0]        next_word  [CHANNELS];

    function automatic logic [7:0] scale_byte(input logic [7:0] x, input logic [7:0] b);
        logic [15:0] f;
        f = {8'd0, b} + 16'd1;
        return 8'(({8'd0, x} * f) >> 8);
    endfunction

    // Colour-order permutation followed by per-byte brightness scaling.
    function automatic logic [23:0] prep_word(input logic [23:0] w, input logic [7:0] b,
                                              input logic [1:0] o);
        logic [23:0] p;
        case (o)
            2'd1:    p = {w[15:8], w[23:16], w[7:0]};
            2'd2:    p = {w[7:0], w[15:8], w[23:16]};
            default: p = w;
        endcase
        return {scale_byte(p[23:16], b), scale_byte(p[15:8], b), scale_byte(p[7:0], b)};
    endfunction

    // Word prepared straight from the live inputs so bit 0 can leave on the accept edge,
    // and the next shadow word prepared from the snapshot for each word boundary.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            first_word[c] = prep_word(led_rgb[c*SLICE + SLICE - 24 +: 24], brightness, order);
            next_word[c]  = prep_word(shadow[c][SLICE-1 -: 24], shadow_bright, shadow_order);
        end
    end

    // Frame sequencer: accept/snapshot, bit serialisation with sclk generation, latch gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            bit_in_word   <= '0;
            div_cnt       <= '0;
            lat_cnt       <= '0;
            shadow_bright <= '0;
            shadow_order  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sclk          <= 1'b0;
            sdo           <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow[c]  <= '0;
                word_sr[c] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= SHIFT;
                        busy          <= 1'b1;
                        bit_cnt       <= '0;
                        bit_in_word   <= '0;
                        div_cnt       <= '0;
                        sclk          <= 1'b0;
                        shadow_bright <= brightness;
                        shadow_order  <= order;
                        for (int c = 0; c < CHANNELS; c++) begin
                            shadow[c]  <= led_rgb[c*SLICE +: SLICE] << 24;
                            word_sr[c] <= first_word[c][22:0];
                            sdo[c]     <= first_word[c][23];
                        end
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        // Bit boundary: sclk falls and sdo moves on in the same cycle.
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state   <= LATCH;
                            lat_cnt <= '0;
                            sdo     <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_in_word == 5'd23) begin
                                bit_in_word <= '0;
                                for (int c = 0; c < CHANNELS; c++) begin
                                    word_sr[c] <= next_word[c][22:0];
                                    sdo[c]     <= next_word[c][23];
                                    shadow[c]  <= shadow[c] << 24;
                                end
                            end else begin
                                bit_in_word <= bit_in_word + 1'b1;
                                for (int c = 0; c < CHANNELS; c++) begin
                                    word_sr[c] <= {word_sr[c][21:0], 1'b0};
                                    sdo[c]     <= word_sr[c][22];
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        sclk    <= ((div_cnt + 1'b1) >= DIV_HALF);
                    end
                end

                LATCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sclk  <= 1'b0;
                    sdo   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2801_multi_driver.sv
// tb_ws2801_multi_driver: random and directed frames scored against a byte-level reference model.
// Latency: expected frames queued at issue, popped by the monitor on each done pulse.
// Backpressure: stimulus waits for frame completion with a bounded wait.
module tb_ws2801_multi_driver;

    localparam int TL    = 2;
    localparam int TC    = 2;
    localparam int DIV   = 4;
    localparam int NB    = TL * 24;
    localparam int LATC  = 8;
    localparam int FRAME = NB * DIV + LATC;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [TC*TL*24-1:0]   led_rgb = '0;
    logic [7:0]            brightness = 8'hFF;
    logic [1:0]            order = 2'd0;
    logic                  start = 1'b0;
    logic                  busy;
    logic                  done;
    logic                  sclk;
    logic [TC-1:0]         sdo;

    ws2801_multi_driver #(
        .LEDS(TL), .CHANNELS(TC), .FREQ(4_000_000), .SCLK_DIV(DIV), .LATCH_US(2)
    ) dut (
        .clk(clk), .rst(rst), .led_rgb(led_rgb), .brightness(brightness), .order(order),
        .start(start), .busy(busy), .done(done), .sclk(sclk), .sdo(sdo)
    );

    always #5 clk = ~clk;

    typedef logic [TC-1:0][NB-1:0] frame_t;

    frame_t exp_q[$];
    int     done_cyc[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     frames_done = 0;
    int     wait_target = 0;
    frame_t last_cap = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference: permute bytes by colour order, scale each by (brightness+1)/256, MSB-first.
    function automatic frame_t model(input logic [TC*TL*24-1:0] rgb, input logic [7:0] br,
                                     input logic [1:0] ord);
        frame_t      f;
        logic [23:0] w;
        int          x[3];
        int          y[3];
        f = '0;
        for (int c = 0; c < TC; c++) begin
            for (int i = 0; i < TL; i++) begin
                w = rgb[c*NB + (TL-1-i)*24 +: 24];
                x[0] = int'(w[23:16]);
                x[1] = int'(w[15:8]);
                x[2] = int'(w[7:0]);
                case (ord)
                    2'd1:    begin y[0] = x[1]; y[1] = x[0]; y[2] = x[2]; end
                    2'd2:    begin y[0] = x[2]; y[1] = x[1]; y[2] = x[0]; end
                    default: begin y[0] = x[0]; y[1] = x[1]; y[2] = x[2]; end
                endcase
                for (int j = 0; j < 3; j++)
                    f[c][NB-1-24*i-8*j -: 8] = 8'((y[j] * (int'(br) + 1)) / 256);
            end
        end
        return f;
    endfunction

    // Monitor: collects bits at sclk rising edges, checks timing and quiet periods, scores on done.
    int          cyc = 0;
    int          e0c = 0;
    int          nbits = 0;
    logic        in_frame = 1'b0;
    logic        prev_sclk = 1'b0;
    logic        prev_busy = 1'b0;
    logic [TC-1:0] prev_sdo = '0;
    frame_t      cap = '0;
    frame_t      exp_f;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame  = 1'b0;
            prev_sclk = 1'b0;
            prev_busy = 1'b0;
            prev_sdo  = '0;
        end else begin
            if (busy && !prev_busy) begin
                in_frame = 1'b1;
                e0c      = cyc;
                nbits    = 0;
                cap      = '0;
            end
            if (sclk && !prev_sclk) begin
                check("sclk_rise_time", cyc, e0c + nbits*DIV + DIV/2);
                if (nbits < NB)
                    for (int c = 0; c < TC; c++) cap[c][NB-1-nbits] = sdo[c];
                nbits++;
            end else if (sclk && prev_sclk) begin
                check("sdo_hold_high", sdo, prev_sdo);
            end
            if (!busy)
                check("idle_quiet", {sclk, sdo}, 0);
            else if (in_frame && (cyc - e0c) >= NB*DIV)
                check("latch_quiet", {sclk, sdo}, 0);
            if (done) begin
                check("done_busy_low", busy, 0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done at cycle %0d, want no frame pending", cyc);
                end else begin
                    exp_f = exp_q.pop_front();
                    check("frame_bits", cap, exp_f);
                    check("bit_count", nbits, NB);
                    check("done_latency", cyc - e0c, FRAME);
                end
                last_cap = cap;
                done_cyc.push_back(cyc);
                frames_done++;
                in_frame = 1'b0;
            end
            prev_sclk = sclk;
            prev_busy = busy;
            prev_sdo  = sdo;
        end
    end

    task automatic issue(input logic [TC*TL*24-1:0] rgb, input logic [7:0] br, input logic [1:0] ord);
        @(negedge clk);
        led_rgb    = rgb;
        brightness = br;
        order      = ord;
        start      = 1'b1;
        exp_q.push_back(model(rgb, br, ord));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        wait_target = target;
        fork
            wait (frames_done >= wait_target);
            repeat (3000) @(negedge clk);
        join_any
        disable fork;
        check("frame_complete", frames_done >= target, 1);
    endtask

    function automatic logic [TC*TL*24-1:0] rnd_rgb();
        return {$urandom, $urandom, $urandom};
    endfunction

    logic [TC*TL*24-1:0] r;
    int                  n;

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sclk", sclk, 0);
        check("reset_sdo", sdo, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic frame
        issue({48'hFFFFFF000000, 48'h800000000001}, 8'd255, 2'd0);
        wait_frames(1);
        check("basic_ch0", last_cap[0], 48'h800000000001);
        check("basic_ch1", last_cap[1], 48'hFFFFFF000000);

        // Scaling
        r = rnd_rgb();
        issue({r[95:48], 48'hFFFFFF808080}, 8'd127, 2'd0);
        wait_frames(2);
        check("scale_127", last_cap[0], 48'h7F7F7F404040);
        issue(rnd_rgb(), 8'd0, 2'd0);
        wait_frames(3);
        check("scale_0", last_cap, 0);
        issue({r[95:48], 48'h808080808080}, 8'd255, 2'd0);
        wait_frames(4);
        check("scale_255", last_cap[0], 48'h808080808080);

        // Colour order
        issue({r[95:48], 48'h112233112233}, 8'd255, 2'd1);
        wait_frames(5);
        check("order_grb", last_cap[0], 48'h221133221133);
        issue({r[95:48], 48'h112233112233}, 8'd255, 2'd2);
        wait_frames(6);
        check("order_bgr", last_cap[0], 48'h332211332211);
        issue({r[95:48], 48'h112233112233}, 8'd255, 2'd3);
        wait_frames(7);
        check("order_3", last_cap[0], 48'h112233112233);

        // Random frames
        for (int i = 0; i < 10; i++) begin
            issue(rnd_rgb(), 8'($urandom), 2'($urandom_range(0, 3)));
            wait_frames(8 + i);
        end

        // Isolation: new data and a start pulse mid-frame must not disturb the frame in flight
        n = frames_done;
        issue(rnd_rgb(), 8'($urandom), 2'($urandom_range(0, 3)));
        repeat (49) @(negedge clk);
        led_rgb    = rnd_rgb();
        brightness = 8'($urandom);
        order      = 2'($urandom_range(0, 3));
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_frames(n + 1);
        repeat (30) @(negedge clk);
        check("isolation_one_frame", frames_done, n + 1);
        check("isolation_idle", busy, 0);

        // Reset abort mid-shift
        n = frames_done;
        issue(rnd_rgb(), 8'($urandom), 2'($urandom_range(0, 3)));
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sclk", sclk, 0);
        check("abort_sdo", sdo, 0);
        void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (250) @(negedge clk);
        check("abort_no_done", frames_done, n);
        issue(rnd_rgb(), 8'($urandom), 2'($urandom_range(0, 3)));
        wait_frames(n + 1);

        // Back-to-back with start held high
        n = frames_done;
        r = rnd_rgb();
        @(negedge clk);
        led_rgb    = r;
        brightness = 8'd200;
        order      = 2'd1;
        start      = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(r, 8'd200, 2'd1));
        wait_frames(n + 2);
        wait_frames(n + 3);
        start = 1'b0;
        if (done_cyc.size() >= n + 3) begin
            check("b2b_gap1", done_cyc[n+1] - done_cyc[n], FRAME + 1);
            check("b2b_gap2", done_cyc[n+2] - done_cyc[n+1], FRAME + 1);
        end else begin
            check("b2b_done_count", done_cyc.size(), n + 3);
        end
        repeat (20) @(negedge clk);
        check("b2b_stopped", frames_done, n + 3);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
